// File: rtl/processor_mem_pkg.sv
// Shared constants and FSM state type for the on-chip memory block copier.
package processor_mem_pkg;

  // Word-address width and number of valid words of the memory slave.
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 5120;

  // Full 32-bit word lanes on every access.
  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    WR    = 3'd4,
    FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/processor_mem_copier_lat.sv
// Read-latency down-counter: loaded when a read is accepted, it raises
// capture in the cycle whose closing edge sees valid readdata, i.e.
// exactly READ_LATENCY edges after the accepting edge (READ_LATENCY 1..3).
module processor_mem_copier_lat #(
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic capture
);

  localparam logic [1:0] LOAD_VAL = 2'(READ_LATENCY);

  logic [1:0] count;

  // Load on read acceptance, then count down to zero and stop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= 2'd0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != 2'd0) begin
      count <= count - 2'd1;
    end
  end

  assign capture = (count == 2'd1);

endmodule

// File: rtl/processor_mem_copier.sv
// Avalon-MM block copier: moves len words from src to dst, one read then
// one write per word, strictly ascending.
// Optional build macro PROCESSOR_MEM_COPIER_CHECKSUM_EN adds a 32-bit sum of
// every word read (port checksum).
//
// Bus handshake: a request (avm_read or avm_write, never both) together with
// avm_address/avm_writedata is held unchanged for as long as avm_waitrequest
// is high; it is accepted at the first rising edge where request=1 and
// avm_waitrequest=0, and the request drops (or moves on) in the next cycle.
// Control handshake: start is looked at only while idle; busy is high from
// the cycle after that start until the done pulse, which also ends busy.
module processor_mem_copier #(
  parameter int ADDR_W       = processor_mem_pkg::ADDR_W,
  parameter int DEPTH        = processor_mem_pkg::DEPTH,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
`ifdef PROCESSOR_MEM_COPIER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic [2:0]        fsm_state
);

  import processor_mem_pkg::*;

  // Range sums carry one extra bit so src+len can never wrap.
  localparam int              SUM_W     = ADDR_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_EXT = SUM_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
  logic [ADDR_W-1:0] remaining;
  logic [SUM_W-1:0]  src_end;
  logic [SUM_W-1:0]  dst_end;
  logic              range_bad;
  logic              rd_accept;
  logic              capture;

  assign src_end   = {1'b0, cur_src} + {1'b0, remaining};
  assign dst_end   = {1'b0, cur_dst} + {1'b0, remaining};
  assign range_bad = (src_end > DEPTH_EXT) || (dst_end > DEPTH_EXT);
  assign rd_accept = (state == RD) && avm_read && !avm_waitrequest;

  assign busy           = (state != IDLE);
  assign avm_byteenable = BE_ALL;
  assign fsm_state      = state;

  processor_mem_copier_lat #(
    .READ_LATENCY(READ_LATENCY)
  ) u_lat (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (rd_accept),
    .capture(capture)
  );

  // Copy sequencer with registered bus and status outputs; the write-data
  // register doubles as the holding register for the word just read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      done          <= 1'b0;
      error         <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      cur_src       <= '0;
      cur_dst       <= '0;
      remaining     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_src   <= src;
            cur_dst   <= dst;
            remaining <= len;
            error     <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (range_bad) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end else if (remaining == '0) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            avm_read    <= 1'b1;
            avm_address <= cur_src;
            state       <= RD;
          end
        end
        RD: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= RWAIT;
          end
        end
        RWAIT: begin
          if (capture) begin
            avm_writedata <= avm_readdata;
            avm_write     <= 1'b1;
            avm_address   <= cur_dst;
            state         <= WR;
          end
        end
        WR: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            cur_src   <= cur_src + ONE;
            cur_dst   <= cur_dst + ONE;
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              avm_read    <= 1'b1;
              avm_address <= cur_src + ONE;
              state       <= RD;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PROCESSOR_MEM_COPIER_CHECKSUM_EN
  // Running mod-2^32 sum of captured read words, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if ((state == RWAIT) && capture) begin
      checksum <= checksum + avm_readdata;
    end
  end
`endif

endmodule

// File: tb/tb_processor_mem_copier.sv
`timescale 1ns/1ps
module tb_processor_mem_copier;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 5120;
  localparam int RL     = 1;
  localparam int TO_CYC = 4000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] src = '0, dst = '0, len = '0;
  logic        busy, done, error;
  logic [12:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest = 1'b0;
  logic [2:0]  fsm_state;
`ifdef PROCESSOR_MEM_COPIER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  processor_mem_copier #(.READ_LATENCY(RL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .error(error),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
`ifdef PROCESSOR_MEM_COPIER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- memory slave model ----------------
  function automatic logic [31:0] pattern(input int i, input logic [31:0] seed);
    return (32'(i) * 32'h9E37_79B1) ^ seed;
  endfunction

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_pipe [RL];
  logic        stall_en = 1'b0;
  logic        init_req = 1'b0;
  logic [31:0] init_seed = '0;
  logic        poke_en = 1'b0;
  logic [12:0] poke_addr = '0;
  logic [31:0] poke_data = '0;
  int          stall_left = 0;
  int          rd_total = 0;
  int          wr_total = 0;

  always @(posedge clk) begin
    if (init_req) for (int i = 0; i < DEPTH; i++) mem[i] <= pattern(i, init_seed);
    if (poke_en) mem[poke_addr] <= poke_data;
    if (avm_write && !avm_waitrequest) begin
      wr_total <= wr_total + 1;
      if (int'(avm_address) < DEPTH) mem[avm_address] <= avm_writedata;
    end
    if (avm_read && !avm_waitrequest) begin
      rd_total <= rd_total + 1;
      rd_pipe[0] <= (int'(avm_address) < DEPTH) ? mem[avm_address] : 32'hDEAD_BEEF;
    end else begin
      rd_pipe[0] <= 32'hBAD0_BAD0;
    end
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (!stall_en) begin
      avm_waitrequest <= 1'b0;
      stall_left <= 0;
    end else if (stall_left > 0) begin
      avm_waitrequest <= 1'b1;
      stall_left <= stall_left - 1;
    end else if ($urandom_range(0, 2) == 0) begin
      avm_waitrequest <= 1'b1;
      stall_left <= $urandom_range(0, 4);
    end else begin
      avm_waitrequest <= 1'b0;
    end
  end
  assign avm_readdata = rd_pipe[RL-1];

  // Bus-rule monitor: requests held under stall, no read+write, legal address.
  logic        p_stall = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  logic [12:0] p_addr = '0;
  logic [31:0] p_wd = '0;
  int          viol_total = 0;
  always @(negedge clk) begin : mon
    int n;
    n = 0;
    if (reset_n) begin
      if (p_stall && (avm_read !== p_rd || avm_write !== p_wr || avm_address !== p_addr ||
                      (p_wr && avm_writedata !== p_wd))) n++;
      if (avm_read && avm_write) n++;
      if ((avm_read || avm_write) && int'(avm_address) >= DEPTH) n++;
      if (avm_byteenable !== 4'hF) n++;
      if (n != 0) $display("note: bus rule broken at %0t", $time);
    end
    viol_total <= viol_total + n;
    p_stall <= reset_n && (avm_read || avm_write) && avm_waitrequest;
    p_rd    <= avm_read;
    p_wr    <= avm_write;
    p_addr  <= avm_address;
    p_wd    <= avm_writedata;
  end

  // ---------------- scoreboard / reference model ----------------
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit range_err(input logic [12:0] s, input logic [12:0] d, input logic [12:0] l);
    return (int'(s) + int'(l) > DEPTH) || (int'(d) + int'(l) > DEPTH);
  endfunction

  // Ascending word-by-word copy; returns the sum of words read.
  task automatic model_copy(input logic [12:0] s, d, l, input int words, output logic [31:0] sum);
    sum = '0;
    if (range_err(s, d, l)) return;
    for (int i = 0; i < words; i++) begin
      exp_q.push_back(ref_mem[int'(s) + i]);
      sum += exp_q[$];
      ref_mem[int'(d) + i] = exp_q.pop_front();
    end
  endtask

  function automatic int mem_mismatches();
    int m;
    m = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) m++;
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic init_mem(input logic [31:0] seed);
    @(negedge clk); init_seed = seed; init_req = 1'b1;
    @(negedge clk); init_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pattern(i, seed);
  endtask

  task automatic poke(input logic [12:0] a, input logic [31:0] v);
    @(negedge clk); poke_addr = a; poke_data = v; poke_en = 1'b1;
    @(negedge clk); poke_en = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic run_job(input string tag, input logic [12:0] s, d, l, input bit exp_err,
                         input int exp_cyc, input bit chk_cyc, input bit mid_start);
    int rd0, wr0, v0, cyc, nwords;
    logic [31:0] sum;
    nwords = exp_err ? 0 : int'(l);
    model_copy(s, d, l, int'(l), sum);
    rd0 = rd_total; wr0 = wr_total; v0 = viol_total;
    @(negedge clk); src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    check({tag, " busy_after_start"}, 64'(busy), 64'(1));
    check({tag, " error_cleared"}, 64'(error), 64'(0));
    while (!done && cyc < TO_CYC) begin
      @(negedge clk); cyc++;
      if (mid_start && cyc == 4) begin src = 13'd0; dst = 13'd900; len = 13'd3; start = 1'b1; end
      else start = 1'b0;
    end
    start = 1'b0;
    check({tag, " done_seen"}, 64'(done), 64'(1));
    if (chk_cyc) check({tag, " done_latency"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " error"}, 64'(error), 64'(exp_err));
`ifdef PROCESSOR_MEM_COPIER_CHECKSUM_EN
    check({tag, " checksum"}, 64'(checksum), 64'(sum));
`endif
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'(done), 64'(0));
    check({tag, " busy_falls"}, 64'(busy), 64'(0));
    check({tag, " error_sticky"}, 64'(error), 64'(exp_err));
`ifdef PROCESSOR_MEM_COPIER_CHECKSUM_EN
    check({tag, " checksum_stable"}, 64'(checksum), 64'(sum));
`endif
    check({tag, " reads"}, 64'(rd_total - rd0), 64'(nwords));
    check({tag, " writes"}, 64'(wr_total - wr0), 64'(nwords));
    check({tag, " bus_rules"}, 64'(viol_total - v0), 64'(0));
    check({tag, " mem_mismatch"}, 64'(mem_mismatches()), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [12:0] s;
    logic [12:0] d;
    logic [12:0] l;
    bit          err;
    int          cyc;
  } vec_t;
  vec_t tbl [11];

  initial begin
    logic [31:0] dummy;
    int n, wr0;
    logic [12:0] rs, rd, rl;

    tbl[0]  = '{13'd100,  13'd200,  13'd4,    1'b0, 14};
    tbl[1]  = '{13'd300,  13'd310,  13'd0,    1'b0, 2};
    tbl[2]  = '{13'd5118, 13'd0,    13'd4,    1'b1, 2};
    tbl[3]  = '{13'd10,   13'd20,   13'd3,    1'b0, 11};
    tbl[4]  = '{13'd0,    13'd5116, 13'd4,    1'b0, 14};
    tbl[5]  = '{13'd5116, 13'd0,    13'd5,    1'b1, 2};
    tbl[6]  = '{13'd50,   13'd52,   13'd6,    1'b0, 20};
    tbl[7]  = '{13'd60,   13'd58,   13'd4,    1'b0, 14};
    tbl[8]  = '{13'd5119, 13'd1,    13'd1,    1'b0, 5};
    tbl[9]  = '{13'd0,    13'd8191, 13'd1,    1'b1, 2};
    tbl[10] = '{13'd8191, 13'd0,    13'd8191, 1'b1, 2};

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst error", 64'(error), 64'(0));
    check("rst read", 64'(avm_read), 64'(0));
    check("rst write", 64'(avm_write), 64'(0));
    check("rst address", 64'(avm_address), 64'(0));
    check("rst writedata", 64'(avm_writedata), 64'(0));
    check("rst byteenable", 64'(avm_byteenable), 64'(4'hF));
    check("rst state_idle", 64'(fsm_state), 64'(0));
    reset_n = 1'b1;

    init_mem(32'h1234_5678);
    poke(13'd100, 32'h11);
    poke(13'd101, 32'h22);
    poke(13'd102, 32'h33);
    poke(13'd103, 32'h44);

    // Table-driven jobs, no backpressure
    for (int i = 0; i < 11; i++) begin
      run_job($sformatf("vec%0d", i), tbl[i].s, tbl[i].d, tbl[i].l, tbl[i].err, tbl[i].cyc, 1'b1, 1'b0);
`ifdef PROCESSOR_MEM_COPIER_CHECKSUM_EN
      if (i == 0) check("vec0 checksum_aa", 64'(checksum), 64'(32'hAA));
`endif
    end

    // Start pulsed while busy under backpressure must be ignored
    stall_en = 1'b1;
    run_job("mid_start", 13'd700, 13'd800, 13'd6, 1'b0, 0, 1'b0, 1'b1);
    stall_en = 1'b0;

    // Reset during the write of word 2 of 8
    model_copy(13'd1000, 13'd2000, 13'd8, 2, dummy);
    wr0 = wr_total;
    @(negedge clk); src = 13'd1000; dst = 13'd2000; len = 13'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(avm_write && (wr_total - wr0) == 1) && n < 200) begin @(negedge clk); n++; end
    check("midrst reach_word2_write", 64'(n < 200), 64'(1));
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst done", 64'(done), 64'(0));
    check("midrst error", 64'(error), 64'(0));
    check("midrst read", 64'(avm_read), 64'(0));
    check("midrst write", 64'(avm_write), 64'(0));
    check("midrst address", 64'(avm_address), 64'(0));
    check("midrst writedata", 64'(avm_writedata), 64'(0));
    check("midrst state_idle", 64'(fsm_state), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst partial_mem", 64'(mem_mismatches()), 64'(0));
    run_job("post_rst", 13'd1000, 13'd3000, 13'd8, 1'b0, 26, 1'b1, 1'b0);

    // Randomized jobs with backpressure against the reference model
    stall_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rl = 13'($urandom_range(0, 20));
      rs = 13'($urandom_range(0, 4000));
      rd = 13'($urandom_range(0, DEPTH - 1));
      case ($urandom_range(0, 3))
        0: rs = 13'($urandom_range(DEPTH - 24, DEPTH - 1));
        1: rd = rs + 13'($urandom_range(1, (rl > 1) ? int'(rl) - 1 : 1));
        2: rd = 13'($urandom_range(DEPTH - 24, 8191));
        default: ;
      endcase
      run_job($sformatf("rnd%0d", k), rs, rd, rl, range_err(rs, rd, rl), 0, 1'b0, 1'b0);
    end
    stall_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
